// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with one shared period counter.
// Period and duty updates are double-buffered and take effect only at a
// period boundary, so a pulse is never truncated or glitched mid-period.
module pwm_multi_channel #(
  parameter int unsigned         WIDTH        = 16,
  parameter int unsigned         CHANNELS     = 4,
  parameter int unsigned         RESET_PERIOD = 19,
  parameter logic [CHANNELS-1:0] POLARITY     = {CHANNELS{1'b0}}
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm,
  output logic [WIDTH-1:0]          counter,
  output logic                      period_end,
  output logic                      load_pending
);

  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(RESET_PERIOD);

  typedef logic [CHANNELS-1:0][WIDTH-1:0] duty_vec_t;

  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    active_period_q, active_period_d;
  duty_vec_t           active_duty_q, active_duty_d;
  logic [WIDTH-1:0]    pend_period_q, pend_period_d;
  duty_vec_t           pend_duty_q, pend_duty_d;
  logic                load_pending_q, load_pending_d;
  logic                period_end_q, period_end_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  duty_vec_t           duty_in_c;
  logic                wrap_c;

  // Channel i of the flat duty port sits at [i*WIDTH +: WIDTH]; the packed
  // 2-D view places element i at exactly those bits.
  assign duty_in_c = duty;

  // Last count of the current period.
  assign wrap_c = (count_q == active_period_q);

  // Shared period counter and end-of-period marker.
  always_comb begin
    count_d      = count_q;
    period_end_d = 1'b0;
    if (enable) begin
      count_d      = wrap_c ? '0 : count_q + WIDTH'(1);
      period_end_d = wrap_c;
    end else begin
      count_d = '0;
    end
  end

  // Per-channel compare; since count never exceeds the period, a duty above
  // the period saturates to always-active without special handling.
  always_comb begin
    pwm_d = POLARITY;
    if (enable) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (count_q < active_duty_q[i]) ^ POLARITY[i];
      end
    end
  end

  // Double-buffered period/duty update: stage while running, commit at wrap;
  // while idle the counter is parked at 0 so a direct write is safe.
  always_comb begin
    active_period_d = active_period_q;
    active_duty_d   = active_duty_q;
    pend_period_d   = pend_period_q;
    pend_duty_d     = pend_duty_q;
    load_pending_d  = load_pending_q;
    if (!enable) begin
      if (load) begin
        active_period_d = period;
        active_duty_d   = duty_in_c;
        load_pending_d  = 1'b0;
      end
    end else if (wrap_c) begin
      if (load) begin
        active_period_d = period;
        active_duty_d   = duty_in_c;
      end else if (load_pending_q) begin
        active_period_d = pend_period_q;
        active_duty_d   = pend_duty_q;
      end
      load_pending_d = 1'b0;
    end else if (load) begin
      pend_period_d  = period;
      pend_duty_d    = duty_in_c;
      load_pending_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to the idle configuration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q         <= '0;
      active_period_q <= RST_PERIOD;
      active_duty_q   <= '0;
      pend_period_q   <= '0;
      pend_duty_q     <= '0;
      load_pending_q  <= 1'b0;
      period_end_q    <= 1'b0;
      pwm_q           <= POLARITY;
    end else begin
      count_q         <= count_d;
      active_period_q <= active_period_d;
      active_duty_q   <= active_duty_d;
      pend_period_q   <= pend_period_d;
      pend_duty_q     <= pend_duty_d;
      load_pending_q  <= load_pending_d;
      period_end_q    <= period_end_d;
      pwm_q           <= pwm_d;
    end
  end

  assign pwm          = pwm_q;
  assign counter      = count_q;
  assign period_end   = period_end_q;
  assign load_pending = load_pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: two instances (non-inverted and ch1 inverted)
// share stimulus and are checked every cycle against a behavioural model.
module tb_pwm_multi_channel;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 2;
  localparam logic [CH-1:0] POL_A = 2'b00;
  localparam logic [CH-1:0] POL_B = 2'b10;

  logic          clock = 1'b0;
  logic          reset, enable, load;
  logic [W-1:0]  period;
  logic [CH*W-1:0] duty;
  logic [CH-1:0] pwm_a, pwm_b;
  logic [W-1:0]  counter_a, counter_b;
  logic          pe_a, pe_b, lp_a, lp_b;

  always #5 clock = ~clock;

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH), .RESET_PERIOD(19), .POLARITY(POL_A)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .period(period),
    .duty(duty), .pwm(pwm_a), .counter(counter_a), .period_end(pe_a), .load_pending(lp_a));

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH), .RESET_PERIOD(19), .POLARITY(POL_B)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .period(period),
    .duty(duty), .pwm(pwm_b), .counter(counter_b), .period_end(pe_b), .load_pending(lp_b));

  int tests = 0;
  int fails = 0;

  // Behavioural model: position in period, live settings, staged settings.
  int       m_count, m_period, p_period;
  int       m_duty [CH];
  int       p_duty [CH];
  bit       m_pending, m_pe;
  bit [CH-1:0] m_act;

  // Measurements gathered by run_en.
  int hi0, hi1, lo_b1, pe_cnt;
  logic [CH-1:0] first_pwm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_period = 19; p_period = 0;
    for (int i = 0; i < CH; i++) begin m_duty[i] = 0; p_duty[i] = 0; end
    m_pending = 0; m_pe = 0; m_act = '0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input bit en, input bit ld, input int per, input int d0, input int d1);
    bit wrap;
    if (!en) begin
      m_count = 0; m_act = '0; m_pe = 0;
      if (ld) begin m_period = per; m_duty[0] = d0; m_duty[1] = d1; m_pending = 0; end
    end else begin
      wrap = (m_count == m_period);
      for (int i = 0; i < CH; i++) m_act[i] = (m_count < m_duty[i]);
      m_pe = wrap;
      if (wrap) begin
        if (ld) begin m_period = per; m_duty[0] = d0; m_duty[1] = d1; end
        else if (m_pending) begin m_period = p_period; m_duty = p_duty; end
        m_pending = 0;
      end else if (ld) begin
        p_period = per; p_duty[0] = d0; p_duty[1] = d1; m_pending = 1;
      end
      m_count = wrap ? 0 : m_count + 1;
    end
  endtask

  task automatic check_all();
    chk("counter_a", 32'(counter_a), 32'(m_count));
    chk("counter_b", 32'(counter_b), 32'(m_count));
    chk("pwm_a", 32'(pwm_a), 32'(m_act ^ POL_A));
    chk("pwm_b", 32'(pwm_b), 32'(m_act ^ POL_B));
    chk("period_end_a", 32'(pe_a), 32'(m_pe));
    chk("period_end_b", 32'(pe_b), 32'(m_pe));
    chk("load_pending_a", 32'(lp_a), 32'(m_pending));
    chk("load_pending_b", 32'(lp_b), 32'(m_pending));
  endtask

  // Apply inputs, take one edge, advance the model, compare 1 time unit later.
  task automatic cyc(input bit en, input bit ld, input int per, input int d0, input int d1);
    enable = en; load = ld; period = W'(per);
    duty = {W'(d1), W'(d0)};
    @(posedge clock);
    model_step(en, ld, per, d0, d1);
    #1;
    check_all();
    load = 1'b0;
  endtask

  task automatic run_en(input int n);
    hi0 = 0; hi1 = 0; lo_b1 = 0; pe_cnt = 0;
    for (int k = 0; k < n; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (k == 0) first_pwm = pwm_a;
      hi0    += int'(pwm_a[0]);
      hi1    += int'(pwm_a[1]);
      lo_b1  += int'(!pwm_b[1]);
      pe_cnt += int'(pe_a);
    end
  endtask

  task automatic run_until(input int target);
    int k;
    k = 0;
    while (m_count != target && k < 300) begin
      cyc(1, 0, 0, 0, 0);
      k++;
    end
    chk("run_until_bound", 32'(m_count == target), 32'(1));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; period = '0; duty = '0;
    #1;
    model_reset();
    // 1. Reset defaults
    check_all();
    chk("rst_pwm_b_lit", 32'(pwm_b), 32'(2'b10));
    chk("rst_counter_lit", 32'(counter_a), 32'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    run_en(40);
    chk("t1_hi_lit", 32'(hi0 + hi1), 32'(0));
    chk("t1_pe_lit", 32'(pe_cnt), 32'(2));

    // 2. Basic duty loaded while idle
    cyc(0, 1, 19, 2, 10);
    run_en(40);
    chk("t2_first_pwm_lit", 32'(first_pwm), 32'(2'b11));
    chk("t2_ch0_hi_lit", 32'(hi0), 32'(4));
    chk("t2_ch1_hi_lit", 32'(hi1), 32'(20));

    // 3. Buffered update mid-period, then on the wrap edge
    run_until(7);
    cyc(1, 1, 19, 5, 10);
    chk("t3_pending_lit", 32'(lp_a), 32'(1));
    run_until(0);
    chk("t3_pending_clr_lit", 32'(lp_a), 32'(0));
    run_en(20);
    chk("t3_ch0_new_lit", 32'(hi0), 32'(5));
    run_until(19);
    cyc(1, 1, 19, 3, 10);
    chk("t3_wrap_load_lit", 32'(lp_a), 32'(0));
    run_en(20);
    chk("t3_ch0_wrap_lit", 32'(hi0), 32'(3));

    // 4. Boundaries: zero and saturating duty, then period 0
    cyc(0, 1, 19, 0, 25);
    run_en(20);
    chk("t4_zero_lit", 32'(hi0), 32'(0));
    chk("t4_sat_lit", 32'(hi1), 32'(20));
    cyc(0, 1, 0, 1, 1);
    run_en(10);
    chk("t4_p0_pe_lit", 32'(pe_cnt), 32'(10));
    chk("t4_p0_pwm_lit", 32'(hi0 + hi1), 32'(20));

    // 5. Inverted channel and disable/re-enable
    cyc(0, 1, 19, 3, 10);
    run_en(20);
    chk("t5_inv_low_lit", 32'(lo_b1), 32'(10));
    run_until(12);
    cyc(0, 0, 0, 0, 0);
    chk("t5_dis_cnt_lit", 32'(counter_a), 32'(0));
    chk("t5_dis_pwm_lit", 32'(pwm_b), 32'(2'b10));
    chk("t5_dis_pe_lit", 32'(pe_a), 32'(0));
    cyc(1, 0, 0, 0, 0);
    chk("t5_reen_cnt_lit", 32'(counter_a), 32'(1));
    chk("t5_reen_pwm_lit", 32'(pwm_a), 32'(2'b11));

    // 6. Async reset mid-period with an update pending
    run_until(5);
    cyc(1, 1, 19, 7, 7);
    run_until(9);
    #2 reset = 1'b1;
    #1;
    chk("t6_cnt_lit", 32'(counter_a), 32'(0));
    chk("t6_pend_lit", 32'(lp_a), 32'(0));
    chk("t6_pwm_lit", 32'(pwm_b), 32'(2'b10));
    model_reset();
    check_all();
    #1 reset = 1'b0;
    run_en(20);
    chk("t6_duty0_lit", 32'(hi0 + hi1), 32'(0));
    chk("t6_period_lit", 32'(pe_cnt), 32'(1));

    // 7. Randomized operation
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 8) != 0, ($urandom % 6) == 0, int'($urandom % 24),
          int'($urandom % 30), int'($urandom % 30));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
